// File: rtl/ctrl_conditioner_if.sv
// Control-conditioner bus: raw button/frame/sprite-y inputs in, conditioned
// control word, debounced levels and jump FSM state out.
// There is no valid/ready handshake on this bus: i_btn is a free-running
// asynchronous level, i_frame is a one-cycle strobe that qualifies the frame
// latch, jump sequencing and fall-out check, and every output is a plain
// registered level that is valid on every cycle.
interface ctrl_conditioner_if #(
    parameter int CORDW = 16
);
    logic [5:0]              i_btn;
    logic                    i_frame;
    logic signed [CORDW-1:0] i_spry;
    logic [5:0]              o_ctrl;
    logic [5:0]              o_btn_db;
    logic [1:0]              o_jump_state;

    // Driven by the producer of buttons/frame timing (or a testbench).
    modport master (
        output i_btn, i_frame, i_spry,
        input  o_ctrl, o_btn_db, o_jump_state
    );

    // Used by ctrl_conditioner itself.
    modport slave (
        input  i_btn, i_frame, i_spry,
        output o_ctrl, o_btn_db, o_jump_state
    );
endinterface

// File: rtl/ctrl_conditioner.sv
// Button conditioner ahead of the player sprite block: synchronises and
// debounces the raw buttons, frame-aligns movement with left/right
// arbitration, shapes jump into a one-frame request with cooldown and
// respawn into a one-cycle pulse (button or fall-out triggered).
module ctrl_conditioner #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          JUMP_COOLDOWN   = 8,
    parameter int          CORDW           = 16,
    parameter int          V_RES           = 600,
    parameter int          FALL_MARGIN     = 64
) (
    input  logic i_clk_pix,
    input  logic i_rst_n,
    ctrl_conditioner_if.slave bus
);

    localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;
    localparam int CDW = (JUMP_COOLDOWN < 1) ? 1 : $clog2(JUMP_COOLDOWN + 1);
    localparam logic [CDW-1:0] COOL_LOAD = CDW'(JUMP_COOLDOWN);
    // Threshold held one bit wider than the coordinate so the sum cannot wrap.
    localparam logic signed [CORDW:0] FALL_LIMIT = (CORDW+1)'(V_RES + FALL_MARGIN);

    typedef enum logic [1:0] {
        J_IDLE  = 2'd0,
        J_ARMED = 2'd1,
        J_REQ   = 2'd2,
        J_COOL  = 2'd3
    } jump_state_t;

    logic [5:0]              sync_1;
    logic [5:0]              sync_2;
    logic [5:0]              btn_db;
    logic [5:0]              btn_db_q;
    logic [5:0]              db_rise;
    logic                    last_left;
    logic                    eff_left;
    logic                    eff_right;
    logic [3:0]              move_q;
    jump_state_t             jump_q;
    jump_state_t             jump_d;
    logic [CDW-1:0]          cool_q;
    logic [CDW-1:0]          cool_d;
    logic                    resp_pend;
    logic                    resp_pulse;
    logic                    resp_trig;
    logic                    fall_out;
    logic signed [CORDW:0]   spry_ext;

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= bus.i_btn;
            sync_2 <= sync_1;
        end
    end

    // Per-bit debounce: accept a new level only after it has differed from
    // the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    for (genvar n = 0; n < 6; n++) begin : g_db
        logic [15:0] cnt;

        // Count consecutive disagreeing cycles; toggle the accepted level at the limit.
        always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt       <= '0;
                btn_db[n] <= 1'b0;
            end else if (sync_2[n] == btn_db[n]) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt       <= '0;
                btn_db[n] <= ~btn_db[n];
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Delayed copy of the debounced levels for rising-edge detection.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_db_q <= '0;
        end else begin
            btn_db_q <= btn_db;
        end
    end

    assign db_rise = btn_db & ~btn_db_q;

    // Remember which horizontal direction was pressed most recently; a
    // simultaneous press of both carries no new information and is ignored.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_left <= 1'b0;
        end else if (db_rise[0] && !db_rise[1]) begin
            last_left <= 1'b1;
        end else if (db_rise[1] && !db_rise[0]) begin
            last_left <= 1'b0;
        end
    end

    assign eff_left  = btn_db[0] & (~btn_db[1] | last_left);
    assign eff_right = btn_db[1] & (~btn_db[0] | ~last_left);

    // Movement bits only change at frame start so the sprite sees a stable word per frame.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            move_q <= '0;
        end else if (bus.i_frame) begin
            move_q <= {btn_db[3], btn_db[2], eff_right, eff_left};
        end
    end

    // Jump state register with its cooldown frame counter.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            jump_q <= J_IDLE;
            cool_q <= '0;
        end else begin
            jump_q <= jump_d;
            cool_q <= cool_d;
        end
    end

    // Jump sequencing: arm on a press, request for one whole frame, then cool
    // down for JUMP_COOLDOWN frames. Presses outside IDLE are dropped, and a
    // respawn pulse always returns the sequencer to IDLE.
    always_comb begin
        jump_d = jump_q;
        cool_d = cool_q;
        if (resp_pulse) begin
            jump_d = J_IDLE;
            cool_d = '0;
        end else begin
            case (jump_q)
                J_IDLE: begin
                    if (db_rise[4]) jump_d = J_ARMED;
                end
                J_ARMED: begin
                    if (bus.i_frame) jump_d = J_REQ;
                end
                J_REQ: begin
                    if (bus.i_frame) begin
                        if (JUMP_COOLDOWN == 0) begin
                            jump_d = J_IDLE;
                        end else begin
                            jump_d = J_COOL;
                            cool_d = COOL_LOAD;
                        end
                    end
                end
                J_COOL: begin
                    if (bus.i_frame) begin
                        if (cool_q <= CDW'(1)) begin
                            jump_d = J_IDLE;
                            cool_d = '0;
                        end else begin
                            cool_d = cool_q - CDW'(1);
                        end
                    end
                end
                default: begin
                    jump_d = J_IDLE;
                    cool_d = '0;
                end
            endcase
        end
    end

    // Fall-out: sprite top is below the visible area plus margin. Negative
    // coordinates (spawn point above the screen) must never qualify.
    assign spry_ext  = {bus.i_spry[CORDW-1], bus.i_spry};
    assign fall_out  = (spry_ext > FALL_LIMIT);
    assign resp_trig = db_rise[5] | (bus.i_frame & fall_out);

    // Collect respawn triggers during a frame and release one pulse right after i_frame.
    always_ff @(posedge i_clk_pix or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resp_pend  <= 1'b0;
            resp_pulse <= 1'b0;
        end else if (bus.i_frame) begin
            resp_pulse <= resp_pend | resp_trig;
            resp_pend  <= 1'b0;
        end else begin
            resp_pulse <= 1'b0;
            resp_pend  <= resp_pend | resp_trig;
        end
    end

    assign bus.o_ctrl       = {resp_pulse, (jump_q == J_REQ), move_q};
    assign bus.o_btn_db     = btn_db;
    assign bus.o_jump_state = jump_q;

endmodule
